// File: rtl/alu_sequencer.sv
// alu_sequencer: one-at-a-time valid/ready sequencer around the combinational Operator datapath.
// Operator: eleven N+1-bit results; compare yields {a<b, zeros, a==b}, div by zero yields 0.
module Operator #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N:0]   r_mov,
  output logic [N:0]   r_cmp,
  output logic [N:0]   r_add,
  output logic [N:0]   r_sub,
  output logic [N:0]   r_mul,
  output logic [N:0]   r_div,
  output logic [N:0]   r_xor,
  output logic [N:0]   r_and,
  output logic [N:0]   r_not,
  output logic [N:0]   r_shl,
  output logic [N:0]   r_shr
);
  assign r_mov = {1'b0, a};
  assign r_cmp = {(a < b), {(N-1){1'b0}}, (a == b)};
  assign r_add = {1'b0, a} + {1'b0, b};
  assign r_sub = {1'b0, a} - {1'b0, b};
  assign r_mul = {1'b0, a} * {1'b0, b};
  assign r_div = (b == {N{1'b0}}) ? {(N+1){1'b0}} : {1'b0, a / b};
  assign r_xor = {1'b0, a ^ b};
  assign r_and = {1'b0, a & b};
  assign r_not = {1'b0, ~a};
  assign r_shl = {a, 1'b0};
  assign r_shr = {2'b00, a[N-1:1]};
endmodule

module alu_sequencer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   out_result,
  output logic         out_zero,
  output logic         out_carry,
  output logic         out_neg,
  output logic         out_error,
  output logic [15:0]  op_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t       state_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [3:0]   op_q;
  logic [N:0]   result_q;
  logic         zero_q;
  logic         carry_q;
  logic         neg_q;
  logic         error_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic [15:0]  count_q;

  logic [N:0]   r_mov, r_cmp, r_add, r_sub, r_mul, r_div;
  logic [N:0]   r_xor, r_and, r_not, r_shl, r_shr;
  logic [N:0]   result_d;
  logic         error_d;

  Operator #(.N(N)) u_operator (
    .a     (a_q),
    .b     (b_q),
    .r_mov (r_mov),
    .r_cmp (r_cmp),
    .r_add (r_add),
    .r_sub (r_sub),
    .r_mul (r_mul),
    .r_div (r_div),
    .r_xor (r_xor),
    .r_and (r_and),
    .r_not (r_not),
    .r_shl (r_shl),
    .r_shr (r_shr)
  );

  // Result select; div by zero and illegal opcodes force a zero result with error
  always_comb begin
    result_d = {(N+1){1'b0}};
    error_d  = 1'b0;
    case (op_q)
      4'd0:  result_d = r_mov;
      4'd1:  result_d = r_cmp;
      4'd2:  result_d = r_add;
      4'd3:  result_d = r_sub;
      4'd4:  result_d = r_mul;
      4'd5: begin
        if (b_q == {N{1'b0}}) begin
          error_d = 1'b1;
        end else begin
          result_d = r_div;
        end
      end
      4'd6:  result_d = r_xor;
      4'd7:  result_d = r_and;
      4'd8:  result_d = r_not;
      4'd9:  result_d = r_shl;
      4'd10: result_d = r_shr;
      default: error_d = 1'b1;
    endcase
  end

  // Sequencer FSM with registered handshake, result and flag outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= {N{1'b0}};
      b_q         <= {N{1'b0}};
      op_q        <= 4'd0;
      result_q    <= {(N+1){1'b0}};
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      neg_q       <= 1'b0;
      error_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= in_a;
            b_q        <= in_b;
            op_q       <= in_op;
            in_ready_q <= 1'b0;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          result_q    <= result_d;
          zero_q      <= (result_d[N-1:0] == {N{1'b0}});
          carry_q     <= result_d[N];
          neg_q       <= result_d[N-1];
          error_q     <= error_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
            if (count_q != 16'hFFFF) begin
              count_q <= count_q + 16'd1;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_zero   = zero_q;
  assign out_carry  = carry_q;
  assign out_neg    = neg_q;
  assign out_error  = error_q;
  assign op_count   = count_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer (N=4): transaction-level model plus directed literal checks.
module tb_alu_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_result;
  logic        out_zero;
  logic        out_carry;
  logic        out_neg;
  logic        out_error;
  logic [15:0] op_count;

  always #5 clk = ~clk;

  alu_sequencer #(.N(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_carry  (out_carry),
    .out_neg    (out_neg),
    .out_error  (out_error),
    .op_count   (op_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic for a 4-bit operand, 5-bit result datapath
  function automatic void ref_op(input int op, input int a, input int b, output int r, output bit e);
    e = 1'b0;
    r = 0;
    case (op)
      0:  r = a;
      1:  r = ((a < b) ? 16 : 0) + ((a == b) ? 1 : 0);
      2:  r = a + b;
      3:  r = (a - b + 32) % 32;
      4:  r = (a * b) % 32;
      5:  if (b == 0) e = 1'b1; else r = a / b;
      6:  r = a ^ b;
      7:  r = a & b;
      8:  r = 15 - a;
      9:  r = a * 2;
      10: r = a / 2;
      default: e = 1'b1;
    endcase
  endfunction

  // Transaction model: busy from accept until consumed; response visible one edge after accept
  bit m_ok = 1'b0;
  bit m_busy = 1'b0;
  int m_age = 0;
  int m_cnt = 0;
  int m_res = 0;
  bit m_err = 1'b0;
  int cyc = 0;
  int acc_n = 0;
  int acc_t[$];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_ok = 1'b1;
      m_busy = 1'b0;
      m_age = 0;
      m_cnt = 0;
    end else if (m_ok) begin
      if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1'b1;
          m_age = 0;
          ref_op(int'(in_op), int'(in_a), int'(in_b), m_res, m_err);
          acc_n++;
          acc_t.push_back(cyc);
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (out_ready) begin
        m_busy = 1'b0;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (m_ok && !rst) begin
      check("in_ready", int'(in_ready), int'(!m_busy));
      check("out_valid", int'(out_valid), int'(m_busy && m_age == 1));
      check("op_count", int'(op_count), m_cnt);
      if (m_busy && m_age == 1) begin
        check("result", int'(out_result), m_res);
        check("error", int'(out_error), int'(m_err));
        check("zero", int'(out_zero), int'((m_res % 16) == 0));
        check("carry", int'(out_carry), int'(m_res >= 16));
        check("neg", int'(out_neg), (m_res / 8) % 2);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One full transaction with hand-computed expectations; flags are {zero, carry, neg}
  task automatic run_op(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input int exp_r, input bit exp_e, input logic [2:0] exp_f, input string nm);
    int n;
    in_op = op;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({nm, "_accept"}, int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check({nm, "_ready_low"}, int'(in_ready), 0);
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    check({nm, "_latency"}, n, 1);
    check({nm, "_res"}, int'(out_result), exp_r);
    check({nm, "_err"}, int'(out_error), int'(exp_e));
    check({nm, "_flags"}, int'({out_zero, out_carry, out_neg}), int'(exp_f));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({nm, "_ready_back"}, int'(in_ready), 1);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    int         r;
    logic [2:0] f;
  } vec_t;

  vec_t vecs[9] = '{
    '{4'd0,  4'd9,  4'd0, 9,  3'b001},
    '{4'd1,  4'd3,  4'd5, 16, 3'b110},
    '{4'd1,  4'd5,  4'd5, 1,  3'b000},
    '{4'd6,  4'd12, 4'd10, 6, 3'b000},
    '{4'd7,  4'd12, 4'd10, 8, 3'b001},
    '{4'd8,  4'd5,  4'd0, 10, 3'b001},
    '{4'd9,  4'd9,  4'd0, 18, 3'b010},
    '{4'd10, 4'd9,  4'd0, 4,  3'b000},
    '{4'd5,  4'd13, 4'd4, 3,  3'b000}
  };

  initial begin
    int n;
    int base;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_op = 4'd0;
    in_a = 4'd0;
    in_b = 4'd0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_result", int'(out_result), 0);
    check("rst_flags", int'({out_zero, out_carry, out_neg, out_error}), 0);
    check("rst_count", int'(op_count), 0);

    run_op(4'd2, 4'd4, 4'd2, 6, 1'b0, 3'b000, "add_4_2");
    check("count_after_first", int'(op_count), 1);
    run_op(4'd2, 4'd15, 4'd1, 16, 1'b0, 3'b110, "add_15_1");
    run_op(4'd3, 4'd2, 4'd4, 30, 1'b0, 3'b011, "sub_2_4");
    run_op(4'd5, 4'd7, 4'd0, 0, 1'b1, 3'b100, "div_by_zero");
    run_op(4'd12, 4'd3, 4'd3, 0, 1'b1, 3'b100, "illegal_op");
    check("count_after_five", int'(op_count), 5);

    // Backpressure with a competing request held on the input
    in_op = 4'd4;
    in_a = 4'd3;
    in_b = 4'd3;
    in_valid = 1'b1;
    tick();
    in_op = 4'd2;
    in_a = 4'd1;
    in_b = 4'd1;
    tick();
    for (int i = 0; i < 6; i++) begin
      check("bp_result", int'(out_result), 9);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_count", int'(op_count), 5);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_count_after", int'(op_count), 6);
    check("bp_no_accept_in_done", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    tick();
    check("bp_second_res", int'(out_result), 2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_count_final", int'(op_count), 7);

    // Reset while in EXEC
    in_op = 4'd2;
    in_a = 4'd5;
    in_b = 4'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_exec_valid", int'(out_valid), 0);
    check("rst_exec_result", int'(out_result), 0);
    check("rst_exec_ready", int'(in_ready), 1);
    check("rst_exec_count", int'(op_count), 0);
    repeat (3) tick();

    // Reset while in DONE
    in_op = 4'd4;
    in_a = 4'd7;
    in_b = 4'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("done_before_rst", int'(out_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_done_valid", int'(out_valid), 0);
    check("rst_done_result", int'(out_result), 0);
    check("rst_done_flags", int'({out_zero, out_carry, out_neg, out_error}), 0);
    check("rst_done_ready", int'(in_ready), 1);
    check("rst_done_count", int'(op_count), 0);
    repeat (3) tick();

    // Back-to-back with out_ready tied high
    out_ready = 1'b1;
    base = acc_n;
    for (int i = 0; i < 4; i++) begin
      in_op = 4'(i + 2);
      in_a = 4'(i + 5);
      in_b = 4'(i + 1);
      in_valid = 1'b1;
      n = 0;
      while (acc_n <= base + i && n < 10) begin
        tick();
        n++;
      end
      check("b2b_accept_seen", int'(acc_n > base + i), 1);
    end
    in_valid = 1'b0;
    repeat (4) tick();
    out_ready = 1'b0;
    check("b2b_count", int'(op_count), 4);
    for (int i = 1; i < 4; i++) begin
      if (acc_t.size() >= base + 4) begin
        check("b2b_spacing", acc_t[base + i] - acc_t[base + i - 1], 3);
      end else begin
        check("b2b_accept_log", acc_t.size(), base + 4);
      end
    end

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, 1'b0, vecs[i].f, "vec");
    end
    check("count_end", int'(op_count), 13);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
